// File: rtl/sort4_loader.sv
// Packs a serial word stream into the four sort4 operands, then drives sort4's enable for a
// fixed number of cycles and pulses done when its results are valid.
`ifndef OUTPUT_BUF_DATASIZE
`define OUTPUT_BUF_DATASIZE 16
`endif

module sort4_loader #(
  parameter int unsigned   DW          = `OUTPUT_BUF_DATASIZE,
  parameter int unsigned   SORT_CYCLES = 6,
  parameter logic [DW-1:0] PAD_VAL     = '0,
  parameter int unsigned   CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic [DW-1:0]    din,
  input  logic             flush,
  output logic [DW-1:0]    in1,
  output logic [DW-1:0]    in2,
  output logic [DW-1:0]    in3,
  output logic [DW-1:0]    in4,
  output logic             sort_en,
  output logic             done,
  output logic             busy,
  output logic [CNT_W-1:0] group_cnt
);

  localparam logic [7:0] CntLoad = 8'(SORT_CYCLES - 1);

  typedef enum logic [1:0] {StFill, StRun, StWait} state_e;

  state_e            state_q, state_d;
  logic [1:0]        slot_q, slot_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [DW-1:0]     data_q [4];
  logic [DW-1:0]     data_d [4];
  logic              sort_en_q, sort_en_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  grp_q, grp_d;
  logic              accept;
  logic              go;
  logic [2:0]        pad_from;

  assign accept = din_valid && (state_q == StFill);

  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    sort_en_d = 1'b0;
    done_d    = 1'b0;
    grp_d     = grp_q;
    go        = 1'b0;
    // First slot to pad: the accepted word (if any) occupies the current slot.
    pad_from  = accept ? ({1'b0, slot_q} + 3'd1) : {1'b0, slot_q};
    unique case (state_q)
      StFill: begin
        if (accept) begin
          data_d[slot_q] = din;
          if (slot_q == 2'd3 || flush) begin
            go = 1'b1;
          end else begin
            slot_d = slot_q + 2'd1;
          end
        end else if (flush && slot_q != 2'd0) begin
          go = 1'b1;
        end
        if (go) begin
          for (int i = 0; i < 4; i++) begin
            if (i >= int'(pad_from)) data_d[i] = PAD_VAL;
          end
          state_d   = StRun;
          slot_d    = 2'd0;
          cnt_d     = CntLoad;
          sort_en_d = 1'b1;
        end
      end
      StRun: begin
        if (cnt_q == 8'd0) begin
          state_d = StWait;
          done_d  = 1'b1;
        end else begin
          cnt_d     = cnt_q - 8'd1;
          sort_en_d = 1'b1;
        end
      end
      StWait: begin
        state_d = StFill;
        grp_d   = grp_q + 1'b1;
      end
      default: state_d = StFill;
    endcase
    busy_d = (state_d != StFill);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StFill;
      slot_q    <= 2'd0;
      cnt_q     <= 8'd0;
      data_q    <= '{default: '0};
      sort_en_q <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      grp_q     <= '0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      sort_en_q <= sort_en_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      grp_q     <= grp_d;
    end
  end

  assign din_ready = (state_q == StFill);
  assign in1       = data_q[0];
  assign in2       = data_q[1];
  assign in3       = data_q[2];
  assign in4       = data_q[3];
  assign sort_en   = sort_en_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign group_cnt = grp_q;

endmodule

// File: tb/tb_sort4_loader.sv
// Randomised scoreboard bench for sort4_loader: the driver forms groups in a queue model and
// schedules the expected enable/done timeline; a negedge monitor compares every cycle.
module tb_sort4_loader;

  localparam int unsigned DW = 8;
  localparam int unsigned SC = 6;
  localparam int unsigned CW = 2;
  localparam logic [DW-1:0] PAD = 8'd0;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          din_valid = 1'b0;
  logic          din_ready;
  logic [DW-1:0] din = '0;
  logic          flush = 1'b0;
  logic [DW-1:0] in1, in2, in3, in4;
  logic          sort_en, done, busy;
  logic [CW-1:0] group_cnt;

  sort4_loader #(.DW(DW), .SORT_CYCLES(SC), .PAD_VAL(PAD), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din_ready(din_ready), .din(din),
    .flush(flush), .in1(in1), .in2(in2), .in3(in3), .in4(in4), .sort_en(sort_en),
    .done(done), .busy(busy), .group_cnt(group_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int launch = -1000;     // edge index at which the group in flight entered RUN
  int gc_m = 0;           // modelled group counter
  bit mon_on = 1'b0;
  logic [DW-1:0] grp[$];  // words of the group being assembled
  logic [4*DW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic close_group();
    logic [4*DW-1:0] e;
    while (grp.size() < 4) grp.push_back(PAD);
    e = {grp[3], grp[2], grp[1], grp[0]};
    exp_q.push_back(e);
    grp.delete();
    launch = cyc;
  endtask

  task automatic send(input logic [DW-1:0] w, input bit f);
    int n = 0;
    din_valid = 1'b1;
    din = w;
    flush = f;
    while (!din_ready && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) chk("ready_timeout", 0, 1);
    tick();
    grp.push_back(w);
    if (grp.size() == 4 || f) close_group();
    din_valid = 1'b0;
    flush = 1'b0;
  endtask

  task automatic flush_alone();
    bit r;
    flush = 1'b1;
    r = din_ready;
    tick();
    flush = 1'b0;
    if (r && grp.size() > 0) close_group();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    launch = -1000;
    gc_m = 0;
    grp.delete();
    exp_q.delete();
    chk("rst_ops", {in4, in3, in2, in1}, 32'h0);
    chk("rst_ready", {31'b0, din_ready}, 1);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk("drain_timeout", 0, 1);
    tick();
  endtask

  // Per-cycle monitor against the expected RUN/WAIT timeline.
  always @(negedge clk) begin
    if (mon_on) begin
      int rel;
      bit en_e, done_e, run_e;
      rel = cyc - launch;
      en_e = (rel >= 0 && rel < SC);
      done_e = (rel == SC);
      run_e = (rel >= 0 && rel <= SC);
      chk("sort_en", {31'b0, sort_en}, {31'b0, en_e});
      chk("done", {31'b0, done}, {31'b0, done_e});
      chk("din_ready", {31'b0, din_ready}, {31'b0, !run_e});
      chk("busy", {31'b0, busy}, {31'b0, run_e});
      chk("group_cnt", {30'b0, group_cnt}, gc_m % 4);
      if (run_e) begin
        if (exp_q.size() == 0) chk("exp_queue_empty", 0, 1);
        else chk("operands", {in4, in3, in2, in1}, exp_q[0]);
      end
      if (done_e) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        gc_m = (gc_m + 1) % 4;
      end
    end
  end

  initial begin
    tick();
    tick();
    do_reset();
    mon_on = 1'b1;

    // Basic group.
    send(8'd54, 0); send(8'd70, 0); send(8'd1, 0); send(8'd0, 0);
    drain();
    // Partial flush.
    send(8'd9, 0); send(8'd3, 0);
    flush_alone();
    drain();
    // Flush together with a word.
    send(8'd5, 0); send(8'd6, 0); send(8'd7, 1);
    drain();
    // Flush at slot 0 is ignored.
    flush_alone();
    tick(); tick();
    // Word stalled during RUN lands in in1 afterwards.
    send(8'd11, 0); send(8'd12, 0); send(8'd13, 0); send(8'd14, 0);
    send(8'd99, 0);
    chk("stalled_in1", {24'b0, in1}, 32'd99);
    send(8'd1, 0); send(8'd2, 0); send(8'd3, 0);
    drain();
    // Reset during the third sort_en cycle.
    do_reset();
    send(8'd40, 0); send(8'd41, 0); send(8'd42, 0); send(8'd43, 0);
    tick(); tick();
    do_reset();
    chk("rst_gc", {30'b0, group_cnt}, 0);
    tick(); tick();
    // Back-to-back stream of 20 words; counter wraps.
    for (int i = 0; i < 20; i++) send(8'($urandom_range(0, 255)), 0);
    drain();
    // Random traffic.
    for (int i = 0; i < 200; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) flush_alone();
      else if (r == 1) tick();
      else send(8'($urandom_range(0, 255)), ($urandom_range(0, 5) == 0));
    end
    if (grp.size() > 0) flush_alone();
    drain();
    chk("final_queue", exp_q.size(), 0);
    mon_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sort4_loader.md
Name: sort4_loader

Overview:
- Upstream feeder for the sort4 comparator stage.
- Accepts a serial stream of output-buffer words through a valid/ready handshake and packs every four words into the sort4 operands in1..in4.
- Holds the operands stable while asserting sort4's en for a fixed number of cycles, then pulses done when the sort4 results (small1/small2/large1/large2) are valid to sample.
- Supports flushing a partial group, padding the empty slots.

Parameters:
- DW, `OUTPUT_BUF_DATASIZE: data width of every word and every operand.
- SORT_CYCLES, 6: number of consecutive cycles sort_en is held high per group; range 1..255.
- PAD_VAL, 0: value written into unfilled slots on flush.
- CNT_W, 16: width of the group counter.

Ports:
- clk, input, 1: system clock; all logic on rising edge.
- rst, input, 1: synchronous, active-high reset.
- din_valid, input, 1: upstream word valid.
- din_ready, output, 1: loader can accept a word.
- din, input, DW: upstream word.
- flush, input, 1: close the current partial group.
- in1, output, DW: sort4 operand, slot 0.
- in2, output, DW: sort4 operand, slot 1.
- in3, output, DW: sort4 operand, slot 2.
- in4, output, DW: sort4 operand, slot 3.
- sort_en, output, 1: drives sort4 en.
- done, output, 1: one-cycle pulse; sort4 outputs valid this cycle.
- busy, output, 1: high in RUN and WAIT.
- group_cnt, output, CNT_W: number of completed groups.

Behaviour:
- Reset (synchronous, rst=1 at rising edge):
  - state=FILL, slot=0.
  - in1..in4=0, sort_en=0, done=0, busy=0, group_cnt=0.
  - din_ready is combinational from state, so it is 1 after reset.
- Reset mid-operation (any state) aborts the group. No done pulse; partial data is discarded.
- All outputs are registered except din_ready, which is (state==FILL).
- Handshake:
  - A word transfers on a rising edge with din_valid && din_ready.
  - din_ready=0 in RUN and WAIT; din is ignored there.
  - The upstream must hold din/din_valid until accepted.
- FILL state:
  - An accepted word writes slot[slot], where slot 0→in1, 1→in2, 2→in3, 3→in4. Then slot increments.
  - Accepting the word at slot 3 enters RUN. Call that edge t.
- Flush, evaluated only in FILL:
  - flush with slot>0 and no word accepted: slots slot..3 take PAD_VAL; enter RUN.
  - flush together with an accepted word: the word is written first, remaining slots are padded, enter RUN. If the word filled slot 3, this is identical to a normal completion.
  - flush with slot==0 and no word accepted: ignored, no group is formed.
  - flush in RUN or WAIT: ignored, not remembered.
- RUN state:
  - sort_en=1 for exactly SORT_CYCLES cycles, i.e. cycles t+1 .. t+SORT_CYCLES.
  - An internal down-counter times RUN.
  - in1..in4 are held constant.
- WAIT state:
  - Exactly one cycle, t+SORT_CYCLES+1.
  - sort_en=0, done=1, group_cnt increments (visible in the following cycle). Wraps modulo 2^CNT_W.
- Return to FILL:
  - FILL is re-entered at t+SORT_CYCLES+2 with slot=0, din_ready=1.
  - in1..in4 keep their old values until overwritten slot by slot.
- Throughput: back-to-back full groups need 4 + SORT_CYCLES + 1 cycles per group.

Test Plan:
- Basic group: after reset, present 54,70,1,0 with din_valid held 1. Expected response:
  - din_ready stays 1 for 4 accepts.
  - in1=54, in2=70, in3=1, in4=0.
  - sort_en high exactly 6 cycles.
  - done one cycle later; sort4 gives small1=0, small2=1, large1=54, large2=70 at done.
  - group_cnt=1.
- Partial flush: accept 9 and 3, then pulse flush alone. Expected in1=9, in2=3, in3=0, in4=0, then the normal sort_en/done sequence.
- Flush with word: accept 5,6, then present 7 with flush=1 in the same cycle. Expected in3=7, in4=PAD_VAL (0), and RUN entered on that edge.
- Ignored cases:
  - flush at slot 0 → no sort_en, group_cnt unchanged.
  - din_valid during RUN → din_ready=0, no slot write, the stalled word is accepted into in1 after done.
- Reset mid-RUN: assert rst for one cycle at cycle 3 of sort_en. Expected:
  - Next cycle sort_en=0, done never pulses, group_cnt=0, in1..in4=0, din_ready=1.
- Back-to-back and wrap: with CNT_W=2, stream 20 words continuously. Expected:
  - 5 done pulses, each spaced 11 cycles apart.
  - group_cnt sequence 1,2,3,0,1.
